mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit implementing the RV32M operation set for the execute stage, alongside the combinational ALU. Operands are accepted through a valid/ready handshake, processed one bit per clock, and returned through a second valid/ready handshake. Width is parametrised so the same block serves RV32 and narrower test configurations.

## Interface
- WIDTH, 32, operand and result width in bits; even, ≥ 4.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept a request (high only in IDLE).
- i_op  input  3  operation, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_operand_a  input  WIDTH  rs1 / dividend / multiplicand.
- i_operand_b  input  WIDTH  rs2 / divisor / multiplier.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_result  output  WIDTH  result.
- o_err  output  1  op not supported in this build (see Configuration); qualified by o_valid.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: o_ready=1. On i_valid && o_ready, latch op and operands, then:
  - divide with b==0 or signed overflow (DIV/REM, a==most-negative, b==all-ones): load special result, go to DONE.
  - otherwise load magnitude operands, counter=WIDTH-1, go to CALC.
- CALC: one iteration per cycle; counter decrements; after iteration with counter==0, apply sign fixup, go to DONE.
  - Multiply: shift-add on a 2·WIDTH accumulator of |a|·|b|; MUL returns low half, MULH/MULHSU/MULHU high half. Signedness: MUL/MULH both signed, MULHSU a signed b unsigned, MULHU both unsigned. Negate full 2·WIDTH product when signs differ.
  - Divide: restoring division, one quotient bit per cycle. DIV/REM use magnitudes; quotient negated when sign(a)≠sign(b); remainder takes sign of a. DIVU/REMU unsigned.
- Special results: b==0 → DIV/DIVU quotient all-ones, REM/REMU = a. Overflow → DIV = a (most-negative), REM = 0.
- DONE: o_valid=1, o_result/o_err stable. On i_ready go to IDLE. o_ready=0 in CALC and DONE; no request overlaps an outstanding result.
- i_valid/operands ignored outside IDLE.

## Timing
- Accept edge = edge T with i_valid && o_ready.
- Normal ops: o_valid high from cycle T+WIDTH+1 (WIDTH CALC cycles + DONE entry); WIDTH=32 → 33 cycles.
- Special divides: o_valid high from cycle T+1.
- Result consumed on edge with o_valid && i_ready; o_ready high the following cycle; next accept earliest one cycle after that.
- Backpressure: o_result, o_err held unchanged for any number of cycles while i_ready=0.
- Reset (any state, including mid-CALC): next cycle state IDLE, o_ready=1, o_valid=0, o_err=0, o_result=0, counter=0, accumulators cleared. In-flight op discarded, no result produced.
- i_reset takes priority over handshakes in the same cycle.

## Configuration
- MDU_DIV_EN defined: full divide datapath (DIV/DIVU/REM/REMU as above); o_err tied 0.
- MDU_DIV_EN undefined: divider logic omitted; divide ops accepted, go directly to DONE (o_valid at T+1) with o_result=0, o_err=1. Multiply ops unchanged, o_err=0.

## Test plan
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), i_ready=1 -> o_result 0xFFFFFFEB, o_valid exactly 33 cycles after accept, o_ready back next cycle.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each with o_valid one cycle after accept.
- Hold i_ready=0 for 5 cycles in DONE -> o_valid and o_result stable, o_ready=0, new i_valid ignored; result accepted on 6th cycle.
- Assert i_reset at CALC cycle 10 of a DIVU -> next cycle o_ready=1, o_valid=0, o_result=0; no result ever emitted; following MUL 3×4 returns 12. Undefined MDU_DIV_EN build: DIV 10/2 -> o_result 0, o_err=1 at T+1.

Source files
------------

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Brief    : Iterative RV32M multiply/divide unit. Requests are accepted
//            through a valid/ready handshake, processed one bit per clock
//            (shift-add multiply, restoring divide) and returned through a
//            second valid/ready handshake.
//            Build option MDU_DIV_EN: when defined the divide datapath is
//            present; when undefined divide ops complete immediately with
//            o_result=0 and o_err=1.
// Revision : 1.0 - initial release
// ============================================================================
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err
);

    localparam int c_CNT_W = $clog2(WIDTH);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CALC = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [2:0]         r_op;
    logic [c_CNT_W-1:0] r_cnt;
    // Multiply: {partial high half, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] r_acc;
    // Multiply: |multiplicand|. Divide: |divisor|.
    logic [WIDTH-1:0]   r_opnd;
    // Final result must be negated (product, quotient or remainder).
    logic               r_neg;
    logic               r_ready;
    logic               r_valid;
    logic               r_err;
    logic [WIDTH-1:0]   r_result;

    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_mul_res;
    logic [WIDTH-1:0]   w_final;

    // Operand signedness, magnitudes and sign fixup decided at accept time
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        if (!i_op[2]) begin
            // MUL/MULH/MULHSU take a signed; MUL/MULH take b signed
            w_a_signed = (i_op[1:0] != 2'b11);
            w_b_signed = ~i_op[1];
        end else begin
            // DIV/REM are signed, DIVU/REMU unsigned
            w_a_signed = ~i_op[0];
            w_b_signed = ~i_op[0];
        end
        w_a_neg = w_a_signed & i_operand_a[WIDTH-1];
        w_b_neg = w_b_signed & i_operand_b[WIDTH-1];
        w_abs_a = w_a_neg ? -i_operand_a : i_operand_a;
        w_abs_b = w_b_neg ? -i_operand_b : i_operand_b;
        // REM follows the dividend sign; everything else follows sign(a)^sign(b)
        w_neg   = (i_op[2] & i_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    end

    // One shift-add multiply iteration: add multiplicand if LSB set, shift right
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
        w_prod     = r_neg ? -w_step : w_step;
        w_mul_res  = (r_op[1:0] == 2'b00) ? w_prod[WIDTH-1:0]
                                          : w_prod[2*WIDTH-1:WIDTH];
    end

`ifdef MDU_DIV_EN
    logic               w_b_zero;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_special;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_div_res;

    // Divide-by-zero / signed-overflow detection and their fixed results
    always_comb begin
        w_b_zero  = (i_operand_b == '0);
        w_ovf     = ~i_op[0]
                  & (i_operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                  & (&i_operand_b);
        w_special = '0;
        if (w_b_zero) begin
            w_special = i_op[1] ? i_operand_a : {WIDTH{1'b1}};
        end else begin
            w_special = i_op[1] ? {WIDTH{1'b0}} : i_operand_a;
        end
    end

    // One restoring-division iteration: shift in next dividend bit, trial subtract
    always_comb begin
        w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
        if (!w_trial[WIDTH]) begin
            w_div_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_div_next = {r_acc[2*WIDTH-2:0], 1'b0};
        end
        w_step    = r_op[2] ? w_div_next : w_mul_next;
        w_quo     = w_step[WIDTH-1:0];
        w_rem     = w_step[2*WIDTH-1:WIDTH];
        if (r_op[1]) begin
            w_div_res = r_neg ? -w_rem : w_rem;
        end else begin
            w_div_res = r_neg ? -w_quo : w_quo;
        end
        w_final   = r_op[2] ? w_div_res : w_mul_res;
    end
`else
    // Only the multiplier iterates in this build
    always_comb begin
        w_step  = w_mul_next;
        w_final = r_op[2] ? {WIDTH{1'b0}} : w_mul_res;
    end
`endif

    // Control FSM and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= c_S_IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (i_valid) begin
                        r_op    <= i_op;
                        r_ready <= 1'b0;
                        r_err   <= 1'b0;
                        r_neg   <= w_neg;
                        if (i_op[2]) begin
`ifdef MDU_DIV_EN
                            if (w_b_zero || w_ovf) begin
                                r_result <= w_special;
                                r_valid  <= 1'b1;
                                r_state  <= c_S_DONE;
                            end else begin
                                r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                                r_opnd  <= w_abs_b;
                                r_cnt   <= c_CNT_W'(WIDTH-1);
                                r_state <= c_S_CALC;
                            end
`else
                            r_result <= '0;
                            r_err    <= 1'b1;
                            r_valid  <= 1'b1;
                            r_state  <= c_S_DONE;
`endif
                        end else begin
                            r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                            r_opnd  <= w_abs_a;
                            r_cnt   <= c_CNT_W'(WIDTH-1);
                            r_state <= c_S_CALC;
                        end
                    end
                end
                c_S_CALC: begin
                    r_acc <= w_step;
                    if (r_cnt == '0) begin
                        r_result <= w_final;
                        r_valid  <= 1'b1;
                        r_state  <= c_S_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                c_S_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Brief    : Self-checking bench for mdu (WIDTH=32). Directed and random
//            requests are compared against an arithmetic reference model.
//            Honours MDU_DIV_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu;

    localparam int c_W = 32;

    logic           clk = 1'b0;
    logic           i_reset;
    logic           i_valid;
    logic           o_ready;
    logic [2:0]     i_op;
    logic [c_W-1:0] i_operand_a;
    logic [c_W-1:0] i_operand_b;
    logic           o_valid;
    logic           i_ready;
    logic [c_W-1:0] o_result;
    logic           o_err;

    int checks = 0;
    int errors = 0;

    mdu #(.WIDTH(c_W)) u_dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op        (i_op),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    // Reference result computed with 64-bit integer arithmetic
    function automatic logic [31:0] model_result(input logic [2:0] op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          ua;
        longint          ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            3'd0: p = ua * ub;
            3'd1: p = sa * sb;
            3'd2: p = sa * ub;
            3'd3: p = ua * ub;
            default: p = '0;
        endcase
        if (op == 3'd0) return p[31:0];
        if (!op[2])     return p[63:32];
`ifdef MDU_DIV_EN
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : a;
        case (op)
            3'd4: p = sa / sb;
            3'd5: p = ua / ub;
            3'd6: p = sa % sb;
            default: p = ua % ub;
        endcase
        return p[31:0];
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic model_err(input logic [2:0] op);
`ifdef MDU_DIV_EN
        return 1'b0 & op[0];
`else
        return op[2];
`endif
    endfunction

    // Clock edges from accept edge until o_valid is observed
    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (!op[2]) return c_W;
`ifdef MDU_DIV_EN
        if (b == 32'd0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return c_W;
`else
        return (a == b) ? 0 : 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for its result, hold i_ready low for 'hold' cycles, consume
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          lat;
        logic [31:0] exp_r;
        exp_r = model_result(op, a, b);
        check({tag, " idle_ready"}, 64'(o_ready), 64'd1);
        i_valid     = 1'b1;
        i_op        = op;
        i_operand_a = a;
        i_operand_b = b;
        i_ready     = (hold == 0);
        @(posedge clk); #1;
        i_valid     = 1'b0;
        i_op        = 3'($urandom);
        i_operand_a = $urandom;
        i_operand_b = $urandom;
        lat = 0;
        while (!o_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(model_lat(op, a, b)));
        check({tag, " result"}, 64'(o_result), 64'(exp_r));
        check({tag, " err"}, 64'(o_err), 64'(model_err(op)));
        check({tag, " busy_ready"}, 64'(o_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            i_valid     = 1'b1;
            i_op        = 3'($urandom);
            i_operand_a = $urandom;
            i_operand_b = $urandom;
            @(posedge clk); #1;
            check({tag, " hold_valid"}, 64'(o_valid), 64'd1);
            check({tag, " hold_result"}, 64'(o_result), 64'(exp_r));
            check({tag, " hold_err"}, 64'(o_err), 64'(model_err(op)));
            check({tag, " hold_ready"}, 64'(o_ready), 64'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " consumed_valid"}, 64'(o_valid), 64'd0);
        check({tag, " consumed_ready"}, 64'(o_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          seen;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        i_reset     = 1'b1;
        i_valid     = 1'b0;
        i_op        = '0;
        i_operand_a = '0;
        i_operand_b = '0;
        i_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b0;
        check("reset ready", 64'(o_ready), 64'd1);
        check("reset valid", 64'(o_valid), 64'd0);
        check("reset result", 64'(o_result), 64'd0);
        check("reset err", 64'(o_err), 64'd0);

        run_op("mul_7x-3", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 0);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 0);
        run_op("div_5_0", 3'd4, 32'd5, 32'd0, 0);
        run_op("rem_5_0", 3'd6, 32'd5, 32'd0, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_10_2", 3'd4, 32'd10, 32'd2, 0);
        run_op("backpressure", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5);

        // Reset in the middle of an iterating operation
`ifdef MDU_DIV_EN
        i_op = 3'd5;
`else
        i_op = 3'd3;
`endif
        i_valid     = 1'b1;
        i_operand_a = 32'd1000;
        i_operand_b = 32'd7;
        i_ready     = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        check("midreset ready", 64'(o_ready), 64'd1);
        check("midreset valid", 64'(o_valid), 64'd0);
        check("midreset result", 64'(o_result), 64'd0);
        check("midreset err", 64'(o_err), 64'd0);
        seen = 0;
        repeat (c_W + 5) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        check("midreset no_result", 64'(seen), 64'd0);
        run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 0);

        // Randomized requests with biased corner operands
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op("random", rop, ra, rb, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
